// File: rtl/pgr_apb_reg_slave_32bit.sv
// -----------------------------------------------------------------------------
// pgr_apb_reg_slave_32bit
//   APB register-bank responder at the far end of the UART-to-APB bridge.
//   Decodes p_addr[7:2], performs byte-strobed writes and returns read data
//   after WAIT_CYC wait states. Holds scratch/control registers, a free-running
//   counter, sticky event flags with W1C clear, an unmapped-access counter and
//   a masked, registered interrupt.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   p_sel    in   APB select
//   p_ce     in   APB enable (access phase)
//   p_we     in   1 = write, 0 = read
//   p_strb   in   [3:0] write byte strobes
//   p_addr   in   [15:0] byte address (only [7:2] decoded)
//   p_wdata  in   [31:0] write data
//   p_rdy    out  one-cycle transfer-complete pulse
//   p_rdata  out  [31:0] read data, valid while p_rdy = 1
//   evt_in   in   [EVT_W-1:0] event pulses, sampled every cycle
//   cnt_en   out  CTRL[0] mirror
//   irq      out  |(STATUS & IRQ_MASK), registered
// -----------------------------------------------------------------------------
module pgr_apb_reg_slave_32bit #(
   parameter logic [31:0] ID_VALUE = 32'h5047_0001,
   parameter int unsigned WAIT_CYC = 2,
   parameter int unsigned EVT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p_sel,
   input  logic             p_ce,
   input  logic             p_we,
   input  logic [3:0]       p_strb,
   input  logic [15:0]      p_addr,
   input  logic [31:0]      p_wdata,
   output logic             p_rdy,
   output logic [31:0]      p_rdata,
   input  logic [EVT_W-1:0] evt_in,
   output logic             cnt_en,
   output logic             irq
);

   // Word indices of the register map
   localparam logic [5:0] A_ID       = 6'd0;
   localparam logic [5:0] A_SCRATCH  = 6'd1;
   localparam logic [5:0] A_CTRL     = 6'd2;
   localparam logic [5:0] A_STATUS   = 6'd3;
   localparam logic [5:0] A_COUNTER  = 6'd4;
   localparam logic [5:0] A_ERRCNT   = 6'd5;
   localparam logic [5:0] A_IRQ_MASK = 6'd6;
   localparam logic [5:0] A_FIRST_UNMAPPED = 6'd7;

   // The wait counter is loaded with WAIT_CYC-1 so that the ACK state is
   // entered exactly WAIT_CYC cycles after the first access cycle.
   localparam logic [3:0] WAIT_LD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   // Byte-lane merge of a 32-bit register
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

   // Per-bit strobe mask for the EVT_W-wide registers
   function automatic logic [EVT_W-1:0] evt_strb_mask(input logic [3:0] strb);
      logic [EVT_W-1:0] m;
      for (int i = 0; i < int'(EVT_W); i++) begin
         m[i] = strb[i/8];
      end
      return m;
   endfunction

   // Saturating increment for the error counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           state, state_nxt;
   logic [3:0]       wcnt;
   logic             access;
   logic             commit;
   logic             wr_commit;
   logic             rd_commit;
   logic [5:0]       idx;
   logic             unmapped;
   logic             cnt_clr;

   logic [31:0]      scratch;
   logic             ctrl_en;
   logic [31:0]      counter;
   logic [EVT_W-1:0] status, status_nxt;
   logic [EVT_W-1:0] irq_mask, irq_mask_nxt;
   logic [EVT_W-1:0] w1c;
   logic [15:0]      errcnt;
   logic [31:0]      rd_val;
   logic             unused_addr;

   assign unused_addr = ^{p_addr[15:8], p_addr[1:0]};

   assign access   = p_sel & p_ce;
   assign idx      = p_addr[7:2];
   assign unmapped = (idx >= A_FIRST_UNMAPPED);

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         wcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && access) begin
            wcnt <= WAIT_LD;
         end else if (state == S_WAIT && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (access) state_nxt = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
         end
         S_WAIT: begin
            // Master withdrawing select/enable aborts the transfer
            if (!access)            state_nxt = S_IDLE;
            else if (wcnt == 4'd0)  state_nxt = S_ACK;
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      p_rdy     = (state == S_ACK);
      // Both write commit and read-data capture happen on the edge entering ACK
      commit    = (state_nxt == S_ACK);
      wr_commit = commit & p_we;
      rd_commit = commit & ~p_we;
   end

   // ------------------------------------------------------- write decode ----
   always_comb begin
      cnt_clr      = wr_commit && (idx == A_CTRL) && p_strb[0] && p_wdata[1];
      w1c          = '0;
      if (wr_commit && idx == A_STATUS) begin
         w1c = evt_strb_mask(p_strb) & p_wdata[EVT_W-1:0];
      end
      // A new event on the same bit wins over the W1C clear
      status_nxt   = (status & ~w1c) | evt_in;
      irq_mask_nxt = irq_mask;
      if (wr_commit && idx == A_IRQ_MASK) begin
         irq_mask_nxt = (irq_mask & ~evt_strb_mask(p_strb)) |
                        (p_wdata[EVT_W-1:0] & evt_strb_mask(p_strb));
      end
   end

   // --------------------------------------------------------- read mux ------
   always_comb begin
      rd_val = '0;
      case (idx)
         A_ID:       rd_val = ID_VALUE;
         A_SCRATCH:  rd_val = scratch;
         A_CTRL:     rd_val[0] = ctrl_en;
         A_STATUS:   rd_val[EVT_W-1:0] = status;
         A_COUNTER:  rd_val = counter;
         A_ERRCNT:   rd_val[15:0] = errcnt;
         A_IRQ_MASK: rd_val[EVT_W-1:0] = irq_mask;
         default:    rd_val = '0;
      endcase
   end

   // -------------------------------------------------------- registers ------
   always_ff @(posedge clk) begin
      if (rst) begin
         scratch  <= '0;
         ctrl_en  <= 1'b0;
         counter  <= '0;
         status   <= '0;
         irq_mask <= '0;
         errcnt   <= '0;
         p_rdata  <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_commit && idx == A_SCRATCH) begin
            scratch <= byte_merge(scratch, p_wdata, p_strb);
         end
         if (wr_commit && idx == A_CTRL && p_strb[0]) begin
            ctrl_en <= p_wdata[0];
         end
         // Clear takes priority over counting
         if (cnt_clr)      counter <= '0;
         else if (ctrl_en) counter <= counter + 32'd1;

         status   <= status_nxt;
         irq_mask <= irq_mask_nxt;
         irq      <= |(status_nxt & irq_mask_nxt);

         if (commit && unmapped) begin
            errcnt <= sat_inc16(errcnt);
         end
         if (rd_commit) begin
            p_rdata <= rd_val;
         end
      end
   end

   assign cnt_en = ctrl_en;

endmodule
